sel_scan_ctrl: RTL

//  - Upstream driver for the 2-to-4 behavioural decoder: produces the 2-bit select (sel -> decoder in[1:0]).
//  - Steps sel through 0,1,2,3,0,... and holds each value for a programmable number of cycles (dwell).
//  - Typical use: display/row multiplexing, where the decoder output enables one of four lines.
//  - Provides start/stop control, a valid flag and a wrap pulse.

---
 rtl/sel_scan_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/sel_scan_ctrl.sv
// Scan controller driving the 2-bit select of a 2-to-4 decoder, one slot of dwell+1 cycles per value.
// Optional macro SCAN_DIR_EN adds a dir input for down-counting (0,3,2,1,0).
module sel_scan_ctrl #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_DIR_EN
    input  logic               dir,
`endif
    output logic [1:0]         sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               wrap
);

    // state    | meaning
    // IDLE     | not scanning, sel parked at 0
    // RUN      | scanning, advancing sel at each slot end
    // STOPPING | stop seen, finishing the current slot
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RUN      = 2'd1;
    localparam logic [1:0] STOPPING = 2'd2;

    logic [1:0]         state;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_q;
    logic [1:0]         next_sel;
    logic               cnt_zero;

    assign cnt_zero = (cnt == '0);

    always_comb begin
`ifdef SCAN_DIR_EN
        next_sel = dir ? (sel - 2'd1) : (sel + 2'd1);
`else
        next_sel = sel + 2'd1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= 2'd0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            wrap      <= 1'b0;
            cnt       <= '0;
            dwell_q   <= '0;
        end else begin
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        sel       <= 2'd0;
                        sel_valid <= 1'b1;
                        busy      <= 1'b1;
                        dwell_q   <= dwell;
                        cnt       <= dwell;
                    end
                end
                RUN: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 1'b1;
                        if (stop)
                            state <= STOPPING;
                    end else if (stop) begin
                        // slot ends on this edge, so there is nothing left to drain
                        state     <= IDLE;
                        sel       <= 2'd0;
                        sel_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        sel  <= next_sel;
                        cnt  <= dwell_q;
                        wrap <= (next_sel == 2'd0);
                    end
                end
                STOPPING: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state     <= IDLE;
                        sel       <= 2'd0;
                        sel_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    sel       <= 2'd0;
                    sel_valid <= 1'b0;
                    busy      <= 1'b0;
                    cnt       <= '0;
                end
            endcase
        end
    end

endmodule
